// File: rtl/hex_display_scanner_if.sv
// Bundle between user-logic digit registers and the scanned display pins.
// The master side supplies digits; the slave side is the scanner.
interface hex_display_scanner_if #(
    parameter int N_DIGITS = 4
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                    en;
    logic [4*N_DIGITS-1:0]   digits;
    logic [N_DIGITS-1:0]     blank;
    logic [6:0]              seg;
    logic [N_DIGITS-1:0]     gate;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
        output en,
        output digits,
        output blank,
        input  seg,
        input  gate,
        input  digit_idx,
        input  frame_tick
    );

    modport slave (
        input  en,
        input  digits,
        input  blank,
        output seg,
        output gate,
        output digit_idx,
        output frame_tick
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex seven-segment scanner with dead time,
// per-digit blanking and a frame strobe; all outputs are registered.
module hex_display_scanner #(
    parameter int N_DIGITS    = 4,
    parameter int DIV_COUNT   = 50000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    hex_display_scanner_if.slave bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_SPAN = DIV_COUNT + DEAD_CYCLES;
    localparam int CNT_W = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
    localparam int DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_END = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_LAST);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        DEAD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            nib_q, nib_d;
    logic                  blk_q, blk_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   gate_q, gate_d;
    logic                  tick_q, tick_d;
    logic                  load;
    logic [3:0]            sel_nib;
    logic                  sel_blk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        load    = 1'b0;
        tick_d  = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_END) begin
                        cnt_d  = '0;
                        idx_d  = (idx_q == LAST_IDX) ? '0
                                                     : idx_q + IDX_W'(1);
                        tick_d = (idx_q == LAST_IDX);
                        if (DEAD_CYCLES == 0) begin
                            state_d = SHOW;
                            load    = 1'b1;
                        end else begin
                            state_d = DEAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DEAD: begin
                    if (cnt_q == DEAD_END) begin
                        cnt_d   = '0;
                        state_d = SHOW;
                        load    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Inputs are captured only when a slot opens, so a digit never glitches.
    always_comb begin
        sel_nib = '0;
        sel_blk = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_nib = bus.digits[4*i +: 4];
                sel_blk = bus.blank[i];
            end
        end
        nib_d = load ? sel_nib : nib_q;
        blk_d = load ? sel_blk : blk_q;
    end

    always_comb begin
        gate_d = '0;
        seg_d  = SEG_OFF;
        if (state_d == SHOW) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                gate_d[i] = (idx_d == IDX_W'(i));
            end
            seg_d = blk_d ? SEG_OFF : hex7(nib_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            nib_q   <= '0;
            blk_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            gate_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            blk_q   <= blk_d;
            seg_q   <= seg_d;
            gate_q  <= gate_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.gate       = gate_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = tick_q;
endmodule
